imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction memory: accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words.
- Writes the words into instruction memory at consecutive word-aligned addresses.
- Holds the core (PC/fetch) in reset until the program image is fully loaded.
- Sits between the host/debug byte link and the write port of instructionMem.

Parameters:
- DEPTH, 256, instruction memory depth in 32-bit words; maximum accepted program length.
- BASE_ADDR, 32'h0000_0000, byte address of the first written word.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse; begins a load from IDLE, DONE or ERR.
- byte_in  input  8  stream data byte.
- byte_valid  input  1  byte_in valid.
- byte_ready  output  1  loader can accept a byte this cycle.
- imem_we  output  1  instruction memory write enable, one cycle per word.
- imem_addr  output  32  byte address of the write, always word aligned.
- imem_wdata  output  32  assembled instruction word.
- core_hold  output  1  high keeps the core in reset; low only in DONE.
- done  output  1  level; load completed successfully.
- err  output  1  level; load aborted (bad length or checksum).

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, core_hold=1, byte_ready=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, done=0, err=0, all counters 0.
- A byte transfers only when byte_valid && byte_ready at a rising edge. byte_in is ignored otherwise.
- States: IDLE, LEN, DATA, WRITE, CSUM (feature only), DONE, ERR.
- IDLE: byte_ready=0. start -> LEN; clear byte counters, clear length, imem_addr=BASE_ADDR.
- LEN: byte_ready=1. The first byte is len[7:0] and the second is len[15:8].
  - After the 2nd byte: if len==0 or len>DEPTH -> ERR; else -> DATA.
- DATA: byte_ready=1. Byte k of a word (k=0..3) fills wdata[8k+7:8k]. After byte 3 -> WRITE.
- WRITE: exactly one cycle. imem_we=1, byte_ready=0, imem_addr=current address, imem_wdata=assembled word.
  - On exit: words_written+1 and imem_addr+4.
  - If words_written==len -> DONE (or CSUM when the feature is compiled in); else -> DATA.
- Latency: the 4th byte of a word is accepted in cycle N; imem_we is high in cycle N+1; byte_ready returns high in cycle N+2. Peak throughput is 4 bytes per 5 cycles.
- DONE: done=1, core_hold=0, byte_ready=0. Stays until start; start -> LEN with done=0 and core_hold=1 on the next cycle.
- ERR: err=1, core_hold=1, byte_ready=0. Stays until start; start -> LEN with err=0.
- start in LEN, DATA, WRITE or CSUM is ignored; the load continues.
- imem_addr wraps modulo 2^32. This cannot happen within DEPTH for sane BASE_ADDR and is not checked.
- imem_we is never high outside WRITE. Words written before an ERR or a mid-load reset remain in memory; no rollback.
- Reset asserted mid-load aborts immediately to the IDLE outputs above. core_hold stays 1.

Optional Feature:
- Macro: IMEM_LOADER_CSUM_EN.
- Defined:
  - A running XOR of all payload bytes (length bytes excluded) is kept.
  - After the last WRITE the loader enters CSUM with byte_ready=1 and accepts one trailing byte.
  - Byte equal to XOR -> DONE; mismatch -> ERR.
- Undefined: no CSUM state, no trailing byte; the last WRITE goes directly to DONE.

Test Plan:
- Two-word load: start, bytes 02 00 | 13 05 10 00 | 93 05 20 00 with valid held high -> writes 0x00100513 @0x0 and 0x00200593 @0x4, one imem_we cycle each; then done=1, core_hold=0.
- Zero/oversize length: start, bytes 00 00 -> err=1, no imem_we. Repeat with DEPTH=256 and len bytes 01 01 (257) -> err=1.
- Backpressure/gaps: same image as the two-word load with byte_valid toggling 1-0-0-1 randomly -> identical writes. No byte is accepted while byte_ready=0, including during the WRITE cycle.
- Mid-load reset: drop reset after 6 payload bytes -> outputs immediately at reset values. After release, start plus a full 1-word image (01 00 EF BE AD DE) -> 0xDEADBEEF @0x0, done=1.
- start ignored mid-load: pulse start during DATA -> load proceeds unchanged. A start in DONE re-enters LEN, done=0, core_hold=1.
- With IMEM_LOADER_CSUM_EN: 1-word image 01 00 11 22 33 44 plus trailing 44 -> done=1. Trailing 45 -> err=1 and core_hold=1, with the word 0x44332211 still written @0x0.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction memory loader: receives a length-prefixed byte stream over a
// valid/ready handshake, assembles little-endian 32-bit words, writes them to
// consecutive word addresses and holds the core in reset until the image is in.
// Optional trailing XOR checksum byte: define IMEM_LOADER_CSUM_EN.
module imem_loader #(
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_hold,
    output logic        done,
    output logic        err
);

    localparam int unsigned LEN_W  = 16;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
`ifdef IMEM_LOADER_CSUM_EN
        S_CSUM  = 3'd6,
`endif
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t             state_q, state_n;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_n;
    logic [LEN_W-1:0]   len_q, len_n;
    logic [LEN_W-1:0]   words_q, words_n;
    logic [WORD_W-1:0]  addr_n, wdata_n;
    logic [LEN_W-1:0]   len_full;
    logic               xfer;
    logic               ready_n, we_n, hold_n, done_n, err_n;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]         csum_q, csum_n;
`endif

    assign xfer     = byte_valid && byte_ready;
    assign len_full = {byte_in, len_q[7:0]};

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            len_q      <= '0;
            words_q    <= '0;
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
            byte_ready <= 1'b0;
            imem_we    <= 1'b0;
            core_hold  <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_n;
            byte_cnt_q <= byte_cnt_n;
            len_q      <= len_n;
            words_q    <= words_n;
            imem_addr  <= addr_n;
            imem_wdata <= wdata_n;
            byte_ready <= ready_n;
            imem_we    <= we_n;
            core_hold  <= hold_n;
            done       <= done_n;
            err        <= err_n;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q     <= csum_n;
`endif
        end
    end

    // Next-state, datapath updates and next output values
    always_comb begin
        state_n    = state_q;
        byte_cnt_n = byte_cnt_q;
        len_n      = len_q;
        words_n    = words_q;
        addr_n     = imem_addr;
        wdata_n    = imem_wdata;
`ifdef IMEM_LOADER_CSUM_EN
        csum_n     = csum_q;
`endif

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_n    = S_LEN;
                    byte_cnt_n = '0;
                    len_n      = '0;
                    words_n    = '0;
                    addr_n     = BASE_ADDR;
`ifdef IMEM_LOADER_CSUM_EN
                    csum_n     = '0;
`endif
                end
            end
            S_LEN: begin
                if (xfer) begin
                    if (byte_cnt_q == CNT_W'(0)) begin
                        len_n[7:0] = byte_in;
                        byte_cnt_n = CNT_W'(1);
                    end else begin
                        len_n      = len_full;
                        byte_cnt_n = '0;
                        if ((len_full == '0) || (32'(len_full) > DEPTH)) begin
                            state_n = S_ERR;
                        end else begin
                            state_n = S_DATA;
                        end
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    case (byte_cnt_q)
                        2'd0:    wdata_n[7:0]   = byte_in;
                        2'd1:    wdata_n[15:8]  = byte_in;
                        2'd2:    wdata_n[23:16] = byte_in;
                        default: wdata_n[31:24] = byte_in;
                    endcase
`ifdef IMEM_LOADER_CSUM_EN
                    csum_n = csum_q ^ byte_in;
`endif
                    byte_cnt_n = byte_cnt_q + CNT_W'(1);
                    if (byte_cnt_q == CNT_W'(3)) begin
                        state_n = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                words_n = words_q + LEN_W'(1);
                addr_n  = imem_addr + WORD_W'(4);
                if (words_n == len_q) begin
`ifdef IMEM_LOADER_CSUM_EN
                    state_n = S_CSUM;
`else
                    state_n = S_DONE;
`endif
                end else begin
                    state_n = S_DATA;
                end
            end
`ifdef IMEM_LOADER_CSUM_EN
            S_CSUM: begin
                if (xfer) begin
                    state_n = (byte_in == csum_q) ? S_DONE : S_ERR;
                end
            end
`endif
            default: state_n = S_IDLE;
        endcase

        ready_n = (state_n == S_LEN) || (state_n == S_DATA);
`ifdef IMEM_LOADER_CSUM_EN
        ready_n = ready_n || (state_n == S_CSUM);
`endif
        we_n    = (state_n == S_WRITE);
        hold_n  = (state_n != S_DONE);
        done_n  = (state_n == S_DONE);
        err_n   = (state_n == S_ERR);
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes are queued as stimulus is
// driven and popped when imem_we is observed.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_hold;
    logic        done;
    logic        err;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    wr_t         exp_q[$];
    int          passed = 0;
    int          total  = 0;
    logic [31:0] exp_addr;
    logic [7:0]  tb_csum;

    imem_loader #(.DEPTH(256), .BASE_ADDR(32'h0000_0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Write monitor: every imem_we cycle must match the head of the queue
    always @(negedge clk) begin
        wr_t e;
        if (reset === 1'b1 && imem_we === 1'b1) begin
            chk("ready_during_write", 32'(byte_ready), 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr", imem_addr, e.a);
                chk("write_data", imem_wdata, e.d);
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int n;
        if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        n = 0;
        while (byte_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        wr_t e;
        e.a = exp_addr;
        e.d = w;
        exp_q.push_back(e);
        exp_addr = exp_addr + 32'd4;
        for (int i = 0; i < 4; i++) begin
            tb_csum = tb_csum ^ w[8*i +: 8];
            send_byte(w[8*i +: 8], gaps);
        end
    endtask

    task automatic begin_load(input logic [15:0] len);
        pulse_start();
        exp_addr = 32'h0;
        tb_csum  = 8'h00;
        send_byte(len[7:0], 1'b0);
        send_byte(len[15:8], 1'b0);
    endtask

    // Bring the loader from the last WRITE cycle to its final state
    task automatic end_load();
`ifdef IMEM_LOADER_CSUM_EN
        send_byte(tb_csum, 1'b0);
`else
        @(posedge clk);
        #1;
`endif
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_hold"},  32'(core_hold),  32'd1);
        chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, "_we"},    32'(imem_we),    32'd0);
        chk({tag, "_addr"},  imem_addr,       32'h0);
        chk({tag, "_wdata"}, imem_wdata,      32'h0);
        chk({tag, "_done"},  32'(done),       32'd0);
        chk({tag, "_err"},   32'(err),        32'd0);
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        byte_valid = 1'b0;
        byte_in    = 8'h00;
        exp_addr   = 32'h0;
        tb_csum    = 8'h00;
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(byte_ready), 32'd0);

        // Two-word load with latency checks on the first word
        begin_load(16'd2);
        send_word(32'h0010_0513, 1'b0);
        chk("lat_we_n1",    32'(imem_we),    32'd1);
        chk("lat_ready_n1", 32'(byte_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_we_n2",    32'(imem_we),    32'd0);
        chk("lat_ready_n2", 32'(byte_ready), 32'd1);
        send_word(32'h0020_0593, 1'b0);
        end_load();
        chk("load2_done",  32'(done),       32'd1);
        chk("load2_hold",  32'(core_hold),  32'd0);
        chk("load2_err",   32'(err),        32'd0);
        chk("load2_ready", 32'(byte_ready), 32'd0);
        chk("load2_queue", 32'(exp_q.size()), 32'd0);

        // start in DONE re-enters LEN; then zero length aborts
        pulse_start();
        chk("restart_done",  32'(done),       32'd0);
        chk("restart_hold",  32'(core_hold),  32'd1);
        chk("restart_ready", 32'(byte_ready), 32'd1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        chk("len0_err",   32'(err),        32'd1);
        chk("len0_hold",  32'(core_hold),  32'd1);
        chk("len0_done",  32'(done),       32'd0);
        chk("len0_ready", 32'(byte_ready), 32'd0);
        repeat (3) @(negedge clk);
        chk("len0_err_held", 32'(err), 32'd1);

        // Length one past DEPTH aborts
        begin_load(16'h0101);
        chk("len257_err",  32'(err),       32'd1);
        chk("len257_hold", 32'(core_hold), 32'd1);

        // Backpressure gaps on the byte stream
        begin_load(16'd2);
        send_word(32'h0010_0513, 1'b1);
        send_word(32'h0020_0593, 1'b1);
        end_load();
        chk("gaps_done",  32'(done),          32'd1);
        chk("gaps_err",   32'(err),           32'd0);
        chk("gaps_queue", 32'(exp_q.size()),  32'd0);

        // start pulses during WRITE and DATA are ignored
        begin_load(16'd2);
        send_word(32'h0010_0513, 1'b0);
        pulse_start();
        pulse_start();
        send_word(32'h0020_0593, 1'b0);
        end_load();
        chk("ignstart_done", 32'(done),         32'd1);
        chk("ignstart_hold", 32'(core_hold),    32'd0);
        chk("ignstart_queue", 32'(exp_q.size()), 32'd0);

        // Reset after 6 payload bytes, then a fresh one-word load
        begin_load(16'd2);
        send_word(32'h0010_0513, 1'b0);
        send_byte(8'h93, 1'b0);
        send_byte(8'h05, 1'b0);
        #2 reset = 1'b0;
        #1;
        chk_idle_outputs("midreset");
        @(negedge clk) reset = 1'b1;
        begin_load(16'd1);
        send_word(32'hDEAD_BEEF, 1'b0);
        end_load();
        chk("reload_done", 32'(done),          32'd1);
        chk("reload_hold", 32'(core_hold),     32'd0);
        chk("reload_queue", 32'(exp_q.size()), 32'd0);

`ifdef IMEM_LOADER_CSUM_EN
        // Trailing checksum byte: match then mismatch
        begin_load(16'd1);
        send_word(32'h4433_2211, 1'b0);
        send_byte(8'h44, 1'b0);
        chk("csum_ok_done", 32'(done), 32'd1);
        chk("csum_ok_err",  32'(err),  32'd0);
        begin_load(16'd1);
        send_word(32'h4433_2211, 1'b0);
        send_byte(8'h45, 1'b0);
        chk("csum_bad_err",   32'(err),          32'd1);
        chk("csum_bad_hold",  32'(core_hold),    32'd1);
        chk("csum_bad_done",  32'(done),         32'd0);
        chk("csum_bad_queue", 32'(exp_q.size()), 32'd0);
`endif

        repeat (3) @(negedge clk);
        chk("final_queue", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
